// File: rtl/display_gamma_pkg.sv
// Shared constants for the display gamma pipeline: LUT channel selects and brightness width.
package display_gamma_pkg;

    localparam logic [1:0] CH_R   = 2'd0;
    localparam logic [1:0] CH_G   = 2'd1;
    localparam logic [1:0] CH_B   = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    localparam int unsigned BRIGHT_W = 8;
    localparam int unsigned NUM_CH   = 3;

    // True when a write with select 'sel' targets colour LUT 'ch'.
    function automatic logic lut_hit(input logic [1:0] sel, input logic [1:0] ch);
        return (sel == CH_ALL) || (sel == ch);
    endfunction

endpackage

// File: rtl/display_gamma_lut.sv
// One colour gamma LUT: single write port, SEGMENTS registered read ports, linear power-up contents.
module display_gamma_lut
    import display_gamma_pkg::*;
#(
    parameter int unsigned SEGMENTS   = 1,
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned CYCLEWIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [BITWIDTH-1:0]            waddr,
    input  logic [CYCLEWIDTH-1:0]          wdata,
    input  logic                           ren,
    input  logic [SEGMENTS*BITWIDTH-1:0]   raddr,
    output logic [SEGMENTS*CYCLEWIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << BITWIDTH;
    localparam int unsigned SHIFT = CYCLEWIDTH - BITWIDTH;

    logic [CYCLEWIDTH-1:0] mem [DEPTH];

    // Entries carry their linear value from configuration; reset leaves them untouched.
    for (genvar a = 0; a < DEPTH; a++) begin : g_entry
        logic [CYCLEWIDTH-1:0] entry = CYCLEWIDTH'(a) << SHIFT;

        always_ff @(posedge clk) begin
            if (we && (waddr == BITWIDTH'(a))) begin
                entry <= wdata;
            end
        end

        assign mem[a] = entry;
    end

    // Read registers sample the pre-write entry, so a same-edge write shows up on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (ren) begin
            for (int unsigned s = 0; s < SEGMENTS; s++) begin
                rdata[s*CYCLEWIDTH +: CYCLEWIDTH] <= mem[raddr[s*BITWIDTH +: BITWIDTH]];
            end
        end
    end

endmodule

// File: rtl/display_gamma_pipeline.sv
// Per-channel gamma LUT pipeline with valid/ready flow control.
// Define DISPLAY_GAMMA_BRIGHTNESS_EN to add the brightness port and a global scaling stage.
module display_gamma_pipeline
    import display_gamma_pkg::*;
#(
    parameter int unsigned SEGMENTS   = 1,
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned CYCLEWIDTH = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BITWIDTH*3*SEGMENTS-1:0]   pixel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CYCLEWIDTH*3*SEGMENTS-1:0] cpixel,
    input  logic                             lut_we,
    input  logic [1:0]                       lut_sel,
    input  logic [BITWIDTH-1:0]              lut_addr,
    input  logic [CYCLEWIDTH-1:0]            lut_data
`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
    ,
    input  logic [BRIGHT_W-1:0]              brightness
`endif
);

    localparam int unsigned NCH = NUM_CH * SEGMENTS;

    if (CYCLEWIDTH < BITWIDTH) begin : g_bad_width
        $error("display_gamma_pipeline: CYCLEWIDTH must be >= BITWIDTH");
    end

    logic                           en_c;
    logic                           s1_valid;
    logic [NCH*CYCLEWIDTH-1:0]      s1_data;
    logic [SEGMENTS*BITWIDTH-1:0]   lut_ra [NUM_CH];
    logic [SEGMENTS*CYCLEWIDTH-1:0] lut_rd [NUM_CH];

    // Whole pipeline moves together; a stalled output freezes every stage.
    assign en_c     = !out_valid || out_ready;
    assign in_ready = en_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (en_c) begin
            s1_valid <= in_valid;
        end
    end

    // Gather each colour's channels across segments into that colour's read addresses.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            lut_ra[c] = '0;
            for (int unsigned s = 0; s < SEGMENTS; s++) begin
                lut_ra[c][s*BITWIDTH +: BITWIDTH] = pixel[(NUM_CH*s+c)*BITWIDTH +: BITWIDTH];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lut
        display_gamma_lut #(
            .SEGMENTS   (SEGMENTS),
            .BITWIDTH   (BITWIDTH),
            .CYCLEWIDTH (CYCLEWIDTH)
        ) u_lut (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (lut_we && lut_hit(lut_sel, 2'(c))),
            .waddr (lut_addr),
            .wdata (lut_data),
            .ren   (en_c),
            .raddr (lut_ra[c]),
            .rdata (lut_rd[c])
        );
    end

    // Re-interleave the per-colour read registers into pixel channel order.
    always_comb begin
        s1_data = '0;
        for (int unsigned s = 0; s < SEGMENTS; s++) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                s1_data[(NUM_CH*s+c)*CYCLEWIDTH +: CYCLEWIDTH] = lut_rd[c][s*CYCLEWIDTH +: CYCLEWIDTH];
            end
        end
    end

`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
    localparam int unsigned PROD_W = CYCLEWIDTH + BRIGHT_W + 1;

    logic                      s2_valid;
    logic [NCH*CYCLEWIDTH-1:0] s2_data;

    // Scale by (brightness+1)/256 so full brightness passes the LUT value unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (en_c) begin
            s2_valid <= s1_valid;
            for (int unsigned g = 0; g < NCH; g++) begin
                s2_data[g*CYCLEWIDTH +: CYCLEWIDTH] <= CYCLEWIDTH'(
                    (PROD_W'(s1_data[g*CYCLEWIDTH +: CYCLEWIDTH]) *
                     PROD_W'({1'b0, brightness} + 9'd1)) >> BRIGHT_W);
            end
        end
    end

    assign out_valid = s2_valid;
    assign cpixel    = s2_data;
`else
    assign out_valid = s1_valid;
    assign cpixel    = s1_data;
`endif

endmodule

// File: tb/tb_display_gamma_pipeline.sv
// Scoreboard bench for display_gamma_pipeline (SEGMENTS=2, BITWIDTH=8, CYCLEWIDTH=10).
`timescale 1ns/1ps
module tb_display_gamma_pipeline;

    localparam int unsigned SEG = 2;
    localparam int unsigned BW  = 8;
    localparam int unsigned CW  = 10;
    localparam int unsigned NCH = 3 * SEG;
    localparam int unsigned PW  = BW * NCH;
    localparam int unsigned OW  = CW * NCH;
`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pixel     = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] cpixel;
    logic          lut_we    = 1'b0;
    logic [1:0]    lut_sel   = 2'd0;
    logic [BW-1:0] lut_addr  = '0;
    logic [CW-1:0] lut_data  = '0;
`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif

    typedef struct {
        logic [OW-1:0] data;
        int            acc;
        bit            chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    display_gamma_pipeline #(
        .SEGMENTS   (SEG),
        .BITWIDTH   (BW),
        .CYCLEWIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel     (pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cpixel    (cpixel),
        .lut_we    (lut_we),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data)
`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
        ,
        .brightness(brightness)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] rep_pix(input logic [BW-1:0] v);
        logic [PW-1:0] p;
        for (int i = 0; i < NCH; i++) p[i*BW +: BW] = v;
        return p;
    endfunction

    function automatic logic [OW-1:0] rep_out(input logic [CW-1:0] v);
        logic [OW-1:0] o;
        for (int i = 0; i < NCH; i++) o[i*CW +: CW] = v;
        return o;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [PW-1:0] pix, input logic [OW-1:0] exp, input bit lat);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        pixel    = pix;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back('{data: exp, acc: cyc, chk_lat: lat});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", OW'(exp_q.size()), '0);
    endtask

    task automatic lut_write(input logic [1:0] sel, input logic [BW-1:0] addr, input logic [CW-1:0] data);
        @(negedge clk);
        lut_we   = 1'b1;
        lut_sel  = sel;
        lut_addr = addr;
        lut_data = data;
        @(negedge clk);
        lut_we   = 1'b0;
    endtask

    // Monitor: pops expectations on accepted beats and checks stall stability.
    initial begin : monitor
        logic          prev_stall;
        logic [OW-1:0] prev_cpix;
        exp_t          e;
        prev_stall = 1'b0;
        prev_cpix  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_out_valid", OW'(out_valid), OW'(1));
                check("hold_cpixel", cpixel, prev_cpix);
            end
            if (out_valid && !out_ready) check("stall_in_ready", OW'(in_ready), '0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", cpixel);
                end else begin
                    e = exp_q.pop_front();
                    check("cpixel", cpixel, e.data);
                    if (e.chk_lat) check("latency", OW'(cyc - e.acc), OW'(LAT));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_cpix  = cpixel;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [CW-1:0] ev;
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", OW'(out_valid), '0);
        check("rst_cpixel", cpixel, '0);
        check("rst_in_ready", OW'(in_ready), OW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Linear default contents: value << 2.
        send(rep_pix(8'h80), rep_out(10'h200), 1'b1);
        send(rep_pix(8'h00), rep_out(10'h000), 1'b1);
        send(rep_pix(8'hFF), rep_out(10'h3FC), 1'b1);
        send(48'h06_05_04_03_02_01,
             {10'h018, 10'h014, 10'h010, 10'h00C, 10'h008, 10'h004}, 1'b1);
        drain();

        // Red-only write, then broadcast overwrite.
        lut_write(2'd0, 8'h10, 10'h3FF);
        send(rep_pix(8'h10), {10'h040, 10'h040, 10'h3FF, 10'h040, 10'h040, 10'h3FF}, 1'b0);
        drain();
        lut_write(2'd3, 8'h10, 10'h001);
        send(rep_pix(8'h10), rep_out(10'h001), 1'b0);
        drain();

        // Streaming with 5 cycles of back-pressure.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ev = CW'(8'(32'h20 + i)) << 2;
                    send(rep_pix(8'(32'h20 + i)), rep_out(ev), 1'b0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Brightness scaling on a full-scale entry.
        lut_write(2'd3, 8'h40, 10'h3FF);
`ifdef DISPLAY_GAMMA_BRIGHTNESS_EN
        brightness = 8'd127;
        send(rep_pix(8'h40), rep_out(10'h1FF), 1'b0);
        drain();
        brightness = 8'd0;
        send(rep_pix(8'h40), rep_out(10'h003), 1'b0);
        drain();
        brightness = 8'd255;
`endif
        send(rep_pix(8'h40), rep_out(10'h3FF), 1'b0);
        drain();

        // Reset with beats in flight and the output stalled.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pixel     = rep_pix(8'h80);
        @(negedge clk);
        pixel     = rep_pix(8'h81);
        @(negedge clk);
        in_valid  = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", OW'(out_valid), '0);
        check("rst_mid_cpixel", cpixel, '0);
        check("rst_mid_in_ready", OW'(in_ready), OW'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(rep_pix(8'h10), rep_out(10'h001), 1'b1);
        send(rep_pix(8'h80), rep_out(10'h200), 1'b1);
        drain();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
